// File: rtl/hazard_pkg.sv
// Shared types and widths for the hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int REG_IDX_W  = 5;
    localparam int WD_CNT_W   = 16;
    localparam int PERF_CNT_W = 32;

endpackage

// File: rtl/hazard_ldu_cmp.sv
// Combinational load-use comparator: flags an ID source that needs the result of the
// load currently in EX. ZERO_EXCL ignores destination index 0 (hard-wired x0).
module hazard_ldu_cmp
    import hazard_pkg::*;
#(
    parameter bit ZERO_EXCL = 1'b1
) (
    input  logic                 is_load,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic                 use_rs1,
    input  logic                 use_rs2,
    output logic                 hit
);

    logic rd_live;
    logic src_match;

    assign rd_live   = !ZERO_EXCL || (rd != '0);
    assign src_match = (use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd));
    assign hit       = is_load && we && rd_live && src_match;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: freeze > redirect > load-use > fetch wait.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush/freeze event counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_IDX_W-1:0]  D_rs1,
    input  logic [REG_IDX_W-1:0]  D_rs2,
    input  logic [REG_IDX_W-1:0]  D_rs1_f,
    input  logic [REG_IDX_W-1:0]  D_rs2_f,
    input  logic                  D_use_rs1,
    input  logic                  D_use_rs2,
    input  logic                  D_use_f,
    input  logic [REG_IDX_W-1:0]  E_rd,
    input  logic [REG_IDX_W-1:0]  E_rd_f,
    input  logic                  E_reg_write_enable,
    input  logic                  E_reg_write_enable_f,
    input  logic                  E_wb_data_sel,
    input  logic                  E_redirect,
    input  logic                  im_ready,
    input  logic                  M_dm_req,
    input  logic                  dm_ready,
    output logic                  pc_stall,
    output logic                  FD_stall,
    output logic                  FD_flush,
    output logic                  DE_stall,
    output logic                  DE_flush,
    output logic                  freeze,
    output logic                  redirect_take,
    output logic                  mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PERF_CNT_W-1:0] perf_flush_cnt,
    output logic [PERF_CNT_W-1:0] perf_freeze_cnt
`endif
);

    localparam logic [WD_CNT_W-1:0] WD_LIMIT = WD_CNT_W'(MEM_TIMEOUT - 1);

    state_t              state_reg, state_next;
    logic                redir_pend_reg, redir_pend_next;
    logic [WD_CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
    logic                wd_hit;
    logic                mem_freeze;
    logic                redir_eff;
    logic                ldu_int, ldu_fp, ldu_any;

    hazard_ldu_cmp #(.ZERO_EXCL(1'b1)) u_ldu_int (
        .is_load (E_wb_data_sel),
        .we      (E_reg_write_enable),
        .rd      (E_rd),
        .rs1     (D_rs1),
        .rs2     (D_rs2),
        .use_rs1 (D_use_rs1),
        .use_rs2 (D_use_rs2),
        .hit     (ldu_int)
    );

    // f0 is an ordinary FP register, so no zero exclusion here.
    hazard_ldu_cmp #(.ZERO_EXCL(1'b0)) u_ldu_fp (
        .is_load (E_wb_data_sel),
        .we      (E_reg_write_enable_f),
        .rd      (E_rd_f),
        .rs1     (D_rs1_f),
        .rs2     (D_rs2_f),
        .use_rs1 (D_use_f),
        .use_rs2 (D_use_f),
        .hit     (ldu_fp)
    );

    assign ldu_any = ldu_int || ldu_fp;

    always_comb begin
        state_next = state_reg;
        mem_freeze = 1'b0;
        case (state_reg)
            RUN: begin
                if (M_dm_req && !dm_ready) begin
                    mem_freeze = 1'b1;
                    state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (dm_ready) state_next = RUN;
                else          mem_freeze = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    // A redirect seen while frozen is replayed on the first unfrozen cycle;
    // the frozen EX register still holds the target.
    assign redir_eff       = E_redirect || redir_pend_reg;
    assign redir_pend_next = mem_freeze ? (redir_pend_reg || E_redirect) : 1'b0;

    always_comb begin
        pc_stall      = 1'b0;
        FD_stall      = 1'b0;
        FD_flush      = 1'b0;
        DE_stall      = 1'b0;
        DE_flush      = 1'b0;
        freeze        = 1'b0;
        redirect_take = 1'b0;
        if (!rst) begin
            if (mem_freeze) begin
                freeze = 1'b1;
            end else if (redir_eff) begin
                redirect_take = 1'b1;
                FD_flush      = 1'b1;
                DE_flush      = 1'b1;
            end else if (ldu_any) begin
                pc_stall = 1'b1;
                FD_stall = 1'b1;
                DE_stall = 1'b1;
            end else if (!im_ready) begin
                pc_stall = 1'b1;
                FD_flush = 1'b1;
            end
        end
    end

    always_comb begin
        wd_cnt_next = '0;
        if (state_reg == MEM_WAIT && !dm_ready)
            wd_cnt_next = (wd_cnt_reg == '1) ? wd_cnt_reg : wd_cnt_reg + 1'b1;
    end

    assign wd_hit = (state_reg == MEM_WAIT) && (wd_cnt_reg == WD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= RUN;
            redir_pend_reg <= 1'b0;
            wd_cnt_reg     <= '0;
            mem_timeout    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            redir_pend_reg <= redir_pend_next;
            wd_cnt_reg     <= wd_cnt_next;
            if (wd_hit) mem_timeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [2:0] perf_ev;
    assign perf_ev = {freeze, DE_flush, DE_stall};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [PERF_CNT_W-1:0] cnt_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_reg <= '0;
            else if (perf_ev[gi] && cnt_reg != '1)
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign perf_stall_cnt  = g_perf[0].cnt_reg;
    assign perf_flush_cnt  = g_perf[1].cnt_reg;
    assign perf_freeze_cnt = g_perf[2].cnt_reg;
`endif

endmodule
